// File: rtl/ram_responder_pkg.sv
// Shared encodings for the RAM responder: access size, read/write and handshake FSM states.
package ram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/ram_responder_if.sv
// Control-unit <-> memory handshake bus. The err wire exists only when RAM_ALIGN_CHECK_EN is defined.
interface ram_responder_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              mov;
  logic              rw;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              moc;
  logic              busy;
`ifdef RAM_ALIGN_CHECK_EN
  logic              err;

  modport master (output mov, rw, size, addr, data_in, input data_out, moc, busy, err);
  modport slave  (input mov, rw, size, addr, data_in, output data_out, moc, busy, err);
`else
  modport master (output mov, rw, size, addr, data_in, input data_out, moc, busy);
  modport slave  (input mov, rw, size, addr, data_in, output data_out, moc, busy);
`endif
endinterface

// File: rtl/ram_byte_array.sv
// 2**ADDR_W x 8 storage with four byte lanes at base+0..3 (wrapping), per-lane write enable.
// Lane k sits at bits [31-8k -: 8], so lane 0 is the most-significant byte.
module ram_byte_array #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [7:0]        mem [Depth];
  logic [ADDR_W-1:0] lane_addr [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = base + ADDR_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (we[0]) mem[lane_addr[0]] <= wdata[31:24];
    if (we[1]) mem[lane_addr[1]] <= wdata[23:16];
    if (we[2]) mem[lane_addr[2]] <= wdata[15:8];
    if (we[3]) mem[lane_addr[3]] <= wdata[7:0];
  end

  always_comb begin
    rdata = {mem[lane_addr[0]], mem[lane_addr[1]], mem[lane_addr[2]], mem[lane_addr[3]]};
  end

endmodule

// File: rtl/ram_responder.sv
// Big-endian byte-addressed memory responder for the mov/moc handshake.
// Define RAM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with err.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  ram_responder_if.slave bus
);
  // One extra count gives the acceptance-to-moc distance of WAIT_CYCLES + 2 edges.
  localparam logic [4:0] WaitLoad = 5'(WAIT_CYCLES + 1);

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       data_out_q;
  logic              moc_q;
  logic              busy_q;

  logic [3:0]  lane_mask;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic [31:0] rd_word;
  logic        access_ok;
  logic        access_edge;

  always_comb begin
    lane_mask  = 4'b0000;
    lane_wdata = '0;
    rd_word    = '0;
    unique case (size_q)
      SIZE_BYTE: begin
        lane_mask  = 4'b0001;
        lane_wdata = {data_q[7:0], 24'h0};
        rd_word    = {24'h0, lane_rdata[31:24]};
      end
      SIZE_HALF: begin
        lane_mask  = 4'b0011;
        lane_wdata = {data_q[15:0], 16'h0};
        rd_word    = {16'h0, lane_rdata[31:16]};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = data_q;
        rd_word    = lane_rdata;
      end
    endcase
  end

`ifdef RAM_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q;

  always_comb begin
    misaligned = 1'b0;
    if (size_q == SIZE_HALF) begin
      misaligned = addr_q[0];
    end else if (size_q != SIZE_BYTE) begin
      misaligned = |addr_q[1:0];
    end
  end

  assign access_ok = ~misaligned;
  assign bus.err   = err_q;
`else
  assign access_ok = 1'b1;
`endif

  assign access_edge = (state_q == StWait) && (cnt_q == 5'd0);
  // Reset gates the write so an aborted transaction never reaches memory.
  assign lane_we = (access_edge && !reset && rw_q == RW_WRITE && access_ok) ? lane_mask : 4'b0000;

  ram_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .base (addr_q),
    .we   (lane_we),
    .wdata(lane_wdata),
    .rdata(lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rw_q       <= RW_WRITE;
      size_q     <= SIZE_BYTE;
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      moc_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.mov) begin
            rw_q    <= bus.rw;
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            data_q  <= bus.data_in;
            cnt_q   <= WaitLoad;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 5'd0) begin
            if (rw_q == RW_READ && access_ok) begin
              data_out_q <= rd_word;
            end
            moc_q   <= 1'b1;
`ifdef RAM_ALIGN_CHECK_EN
            err_q   <= misaligned;
`endif
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StDone: begin
          if (!bus.mov) begin
            moc_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.moc      = moc_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (default WAIT_CYCLES=2, ADDR_W=9).
module tb_ram_responder;
  import ram_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ram_responder_if #(.ADDR_W(9)) bus ();

  ram_responder #(
    .ADDR_W     (9),
    .WAIT_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full handshake; lat = edges from the mov-sampling edge to moc rising (-1 on timeout).
  task automatic do_op(input logic rw, input logic [1:0] size, input logic [8:0] addr,
                       input logic [31:0] data, output int lat, output logic [31:0] rd,
                       output logic err_seen, output logic busy1);
    bus.mov     = 1'b1;
    bus.rw      = rw;
    bus.size    = size;
    bus.addr    = addr;
    bus.data_in = data;
    lat         = -1;
    err_seen    = 1'b0;
    busy1       = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 1) busy1 = bus.busy;
      if (bus.moc === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
    rd = bus.data_out;
`ifdef RAM_ALIGN_CHECK_EN
    err_seen = bus.err;
`endif
    bus.mov = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.mov = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({bus.moc, bus.busy, bus.data_out} !== 34'h0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: moc=%b busy=%b data_out=%h want 0 0 0", i, bus.moc,
                 bus.busy, bus.data_out);
      end
    end
  endtask

  task automatic test_word_byte();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    do_op(RW_WRITE, SIZE_WORD, 9'h010, 32'hDEADBEEF, lat, rd, e, b1);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL wr_latency: got %0d want 4", lat);
    end
    total++;
    if (b1 !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept: got %b want 1", b1);
    end
    do_op(RW_READ, SIZE_BYTE, 9'h010, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h0000_00DE) begin
      bad++;
      $display("FAIL rd_byte_010: got %h want 000000de", rd);
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL rd_latency: got %0d want 4", lat);
    end
    do_op(RW_READ, SIZE_BYTE, 9'h013, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h0000_00EF) begin
      bad++;
      $display("FAIL rd_byte_013: got %h want 000000ef", rd);
    end
  endtask

  task automatic test_half();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    do_op(RW_WRITE, SIZE_WORD, 9'h020, 32'h01020304, lat, rd, e, b1);
    do_op(RW_WRITE, SIZE_HALF, 9'h020, 32'hFFFF_A55A, lat, rd, e, b1);
    total++;
    if (rd !== 32'h0000_00EF) begin
      bad++;
      $display("FAIL write_keeps_data_out: got %h want 000000ef", rd);
    end
    do_op(RW_READ, SIZE_WORD, 9'h020, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'hA55A_0304) begin
      bad++;
      $display("FAIL rd_word_020: got %h want a55a0304", rd);
    end
    do_op(RW_READ, SIZE_HALF, 9'h020, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h0000_A55A) begin
      bad++;
      $display("FAIL rd_half_020: got %h want 0000a55a", rd);
    end
  endtask

  task automatic test_hold();
    int lat;
    int moc_cnt;
    logic [31:0] rd;
    logic e, b1;
    bus.mov     = 1'b1;
    bus.rw      = RW_WRITE;
    bus.size    = SIZE_WORD;
    bus.addr    = 9'h030;
    bus.data_in = 32'hCAFEF00D;
    lat         = -1;
    for (int n = 1; n <= 30; n++) begin
      step();
      // Changes after acceptance must be ignored.
      if (n == 1) begin
        bus.data_in = 32'h0BADF00D;
        bus.addr    = 9'h034;
      end
      if (bus.moc === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL hold_latency: got %0d want 4", lat);
    end
    bus.data_in = 32'h12345678;
    moc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.moc === 1'b1) moc_cnt++;
    end
    total++;
    if (moc_cnt !== 10) begin
      bad++;
      $display("FAIL hold_moc: got %0d cycles high want 10", moc_cnt);
    end
    bus.mov = 1'b0;
    step();
    total++;
    if ({bus.moc, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL release: moc=%b busy=%b want 0 0", bus.moc, bus.busy);
    end
    do_op(RW_READ, SIZE_WORD, 9'h030, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL hold_readback: got %h want cafef00d", rd);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int moc_seen;
    logic [31:0] rd;
    logic e, b1;
    do_op(RW_WRITE, SIZE_WORD, 9'h040, 32'hAABBCCDD, lat, rd, e, b1);
    bus.mov     = 1'b1;
    bus.rw      = RW_WRITE;
    bus.size    = SIZE_WORD;
    bus.addr    = 9'h040;
    bus.data_in = 32'h11223344;
    step();
    step();
    reset   = 1'b1;
    bus.mov = 1'b0;
    step();
    reset = 1'b0;
    total++;
    if ({bus.busy, bus.data_out} !== 33'h0) begin
      bad++;
      $display("FAIL abort_reset_state: busy=%b data_out=%h want 0 0", bus.busy, bus.data_out);
    end
    moc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.moc !== 1'b0) moc_seen++;
    end
    total++;
    if (moc_seen !== 0) begin
      bad++;
      $display("FAIL abort_moc: got %0d cycles high want 0", moc_seen);
    end
    do_op(RW_READ, SIZE_WORD, 9'h040, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'hAABBCCDD) begin
      bad++;
      $display("FAIL abort_readback: got %h want aabbccdd", rd);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] rd;
    logic e, b1;
`ifdef RAM_ALIGN_CHECK_EN
    do_op(RW_WRITE, SIZE_WORD, 9'h1FC, 32'h5152A0A1, lat, rd, e, b1);
    total++;
    if (e !== 1'b0) begin
      bad++;
      $display("FAIL aligned_err: got %b want 0", e);
    end
    do_op(RW_WRITE, SIZE_HALF, 9'h000, 32'h0000A2A3, lat, rd, e, b1);
    do_op(RW_WRITE, SIZE_WORD, 9'h1FE, 32'h11223344, lat, rd, e, b1);
    total++;
    if (e !== 1'b1 || lat !== 4) begin
      bad++;
      $display("FAIL misaligned_err: err=%b lat=%0d want 1 4", e, lat);
    end
    do_op(RW_READ, SIZE_WORD, 9'h1FC, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h5152A0A1) begin
      bad++;
      $display("FAIL top_unchanged: got %h want 5152a0a1", rd);
    end
    do_op(RW_READ, SIZE_HALF, 9'h000, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h0000A2A3) begin
      bad++;
      $display("FAIL low_unchanged: got %h want 0000a2a3", rd);
    end
    do_op(RW_READ, SIZE_HALF, 9'h001, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h0000A2A3 || e !== 1'b1) begin
      bad++;
      $display("FAIL misaligned_read: got %h err=%b want 0000a2a3 1", rd, e);
    end
`else
    do_op(RW_WRITE, SIZE_WORD, 9'h1FE, 32'h11223344, lat, rd, e, b1);
    do_op(RW_READ, SIZE_BYTE, 9'h1FE, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h00000011) begin
      bad++;
      $display("FAIL wrap_1fe: got %h want 00000011", rd);
    end
    do_op(RW_READ, SIZE_BYTE, 9'h1FF, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h00000022) begin
      bad++;
      $display("FAIL wrap_1ff: got %h want 00000022", rd);
    end
    do_op(RW_READ, SIZE_BYTE, 9'h000, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h00000033) begin
      bad++;
      $display("FAIL wrap_000: got %h want 00000033", rd);
    end
    do_op(RW_READ, SIZE_BYTE, 9'h001, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h00000044) begin
      bad++;
      $display("FAIL wrap_001: got %h want 00000044", rd);
    end
    do_op(RW_READ, SIZE_WORD, 9'h1FE, 32'h0, lat, rd, e, b1);
    total++;
    if (rd !== 32'h11223344) begin
      bad++;
      $display("FAIL wrap_word: got %h want 11223344", rd);
    end
`endif
  endtask

  initial begin
    reset       = 1'b1;
    bus.mov     = 1'b0;
    bus.rw      = RW_READ;
    bus.size    = SIZE_BYTE;
    bus.addr    = '0;
    bus.data_in = '0;
    test_reset();
    test_word_byte();
    test_half();
    test_hold();
    test_reset_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
